multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Parametrised multicycle control unit for the processor core; successor to the fixed 3-bit-opcode, 13-bit-PC controller.
- Owns the program counter and sequences FETCH/DECODE/EXEC/MEM/WB per instruction.
- Adds a variable-latency memory handshake, branch resolution, and halt (opcode or external request).
- Sits beside the datapath: consumes opcode and branch flag, drives memory strobes, ALU op, register write and PC.

Parameters:
- PC_W, 13, program counter width.
- OPC_W, 3, opcode width; the low 3 bits decode as below, any nonzero upper bit is illegal.
- ALU_W, 3, ALU operation code width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  OPC_W  opcode from the datapath instruction register, valid from DECODE onward
- beq_taken  in  1  datapath equality flag, sampled in EXEC
- branch_target  in  PC_W  branch destination, sampled in EXEC
- mem_ready  in  1  memory completes the current access this cycle
- done  in  1  external halt request (level)
- pc  out  PC_W  current program counter (registered)
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- instr_fetch  out  1  1 = access is an instruction fetch
- ir_load  out  1  datapath latches the instruction this cycle
- alu_op  out  ALU_W  ALU operation
- reg_write  out  1  register-file write enable
- halted  out  1  controller is in HALT
- state  out  3  encoded state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5

Behaviour:
- Opcode map: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 LW, 101 SW, 110 BEQ, 111 HALT.
- alu_op = opcode[2:0] zero-extended for ADD/SUB/AND/OR. LW, SW and BEQ use ADD (000), except BEQ uses SUB (001).
- Reset: state=FETCH, pc=RESET_PC, halted=0. All strobes are combinational from the state, so they are 0 on the first post-reset edge except FETCH strobes. Reset overrides every state, including HALT and a pending memory access.
- FETCH:
  - mem_read=1 and instr_fetch=1 until mem_ready.
  - ir_load = mem_ready (Mealy).
  - On mem_ready go to DECODE; otherwise stay.
- DECODE: one cycle, no strobes.
  - Go to HALT for HALT or an illegal opcode; otherwise go to EXEC.
- EXEC: alu_op is driven.
  - BEQ: pc <= beq_taken ? branch_target : pc+1, then go to FETCH (instruction boundary).
  - LW/SW: go to MEM.
  - ALU ops: go to WB.
- MEM: mem_read=1 (LW) or mem_write=1 (SW), with instr_fetch=0, held until mem_ready.
  - On mem_ready: LW goes to WB; SW does pc <= pc+1 and goes to FETCH.
- WB: reg_write=1 for one cycle; pc <= pc+1; go to FETCH.
- Minimum latency with zero-wait memory: BEQ 3, ALU 4, SW 4, LW 5 cycles. Each memory wait cycle adds one.
- PC arithmetic is modulo 2^PC_W: pc = 2^PC_W-1 increments to 0.
- done is checked only at instruction boundaries, i.e. on any transition that would enter FETCH.
  - If done=1 at that edge: the PC update still occurs, then the controller goes to HALT instead of FETCH.
  - done asserted mid-instruction never truncates a memory access or a write-back.
- HALT: halted=1, all strobes 0, pc frozen. Only reset exits.
- mem_ready outside FETCH/MEM is ignored.

Optional Feature:
- Macro SINGLE_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - At every instruction boundary (including after reset) the controller enters an extra WAIT state (encoding 6) with all strobes 0.
  - It leaves WAIT for FETCH on the first cycle step=1.
  - done is also honoured while in WAIT (WAIT goes to HALT).
- When undefined: no step port, no WAIT state, free-running as above.

Test Plan:
- Reset, mem_ready tied 1, opcode stream ADD(000) -> pc 0->1 after exactly 4 cycles; reg_write high only in cycle 4; alu_op=000 in EXEC.
- LW (100) with mem_ready low 2 cycles in MEM -> total 7 cycles; mem_read=1 and instr_fetch=0 during MEM; reg_write pulse once; pc=1.
- BEQ (110), beq_taken=1, branch_target=13'h0ABC -> pc=0ABC after 3 cycles, alu_op=001 in EXEC, no reg_write. Repeat with beq_taken=0 -> pc=1.
- RESET_PC=13'h1FFF, ADD -> pc wraps to 0.
- done raised during the MEM stall of SW -> mem_write held until mem_ready, pc increments, then state=5 and halted=1. Opcode 111 -> HALT after DECODE, pc unchanged. Reset mid-HALT -> FETCH, pc=RESET_PC.
- SINGLE_STEP_EN: no fetch until a step pulse; one pulse -> exactly one instruction executes, then the controller returns to WAIT (state=6).

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multicycle control unit. Owns the program counter and steps each instruction
// through FETCH / DECODE / EXEC / MEM / WB. Memory accesses may take any number
// of cycles (mem_ready handshake). Halt comes from the HALT opcode, an illegal
// opcode, or the external done request at an instruction boundary.
//
// Optional build macro: SINGLE_STEP_EN
//   Adds a 'step' input and a WAIT state (encoding 6). The controller parks in
//   WAIT after reset and after every instruction, then fetches once per step.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int              PC_W     = 13,
   parameter int              OPC_W    = 3,
   parameter int              ALU_W    = 3,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [OPC_W-1:0] opcode,
   input  logic             beq_taken,
   input  logic [PC_W-1:0]  branch_target,
   input  logic             mem_ready,
   input  logic             done,
`ifdef SINGLE_STEP_EN
   input  logic             step,
`endif
   output logic [PC_W-1:0]  pc,
   output logic             mem_read,
   output logic             mem_write,
   output logic             instr_fetch,
   output logic             ir_load,
   output logic [ALU_W-1:0] alu_op,
   output logic             reg_write,
   output logic             halted,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5,
      ST_WAIT   = 3'd6
   } state_e;

   // Where an instruction ends: straight back to FETCH, or parked in WAIT
   // when single-stepping. Reset lands in the same place.
`ifdef SINGLE_STEP_EN
   localparam state_e BOUNDARY_ST = ST_WAIT;
`else
   localparam state_e BOUNDARY_ST = ST_FETCH;
`endif

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;

   // ---------------------------------------------------------------------------
   // Opcode decode. Only the low three bits select an operation; any set bit
   // above them makes the opcode illegal, which is treated like HALT.
   // ---------------------------------------------------------------------------
   logic [2:0]      opc_low;
   logic            opc_illegal;
   logic            is_lw, is_sw, is_beq, is_halt;
   logic [PC_W-1:0] pc_inc;

   assign opc_low     = opcode[2:0];
   assign opc_illegal = (opcode >> 3) != '0;
   assign is_lw       = (opc_low == 3'b100);
   assign is_sw       = (opc_low == 3'b101);
   assign is_beq      = (opc_low == 3'b110);
   assign is_halt     = (opc_low == 3'b111);
   // Natural wrap: 2^PC_W-1 + 1 = 0.
   assign pc_inc      = pc_q + PC_W'(1);

   // State and PC registers with synchronous reset overriding every state.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all state so every register samples
      // the pre-edge values regardless of statement order.
      if (reset) begin
         state_q <= BOUNDARY_ST;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Next-state and next-PC logic; instruction boundaries divert to HALT on done.
   always_comb begin
      logic boundary;
      // NOTE: every comb output gets a default first, so no path can leave
      // it unassigned and infer a latch.
      state_d  = state_q;
      pc_d     = pc_q;
      boundary = 1'b0;

      unique case (state_q)
         ST_FETCH: begin
            if (mem_ready) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            if (is_halt || opc_illegal) state_d = ST_HALT;
            else                        state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (is_beq) begin
               pc_d     = beq_taken ? branch_target : pc_inc;
               boundary = 1'b1;
            end else if (is_lw || is_sw) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            // The access is never abandoned: only mem_ready moves us on.
            if (mem_ready) begin
               if (is_sw) begin
                  pc_d     = pc_inc;
                  boundary = 1'b1;
               end else begin
                  state_d = ST_WB;
               end
            end
         end
         ST_WB: begin
            pc_d     = pc_inc;
            boundary = 1'b1;
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
`ifdef SINGLE_STEP_EN
         ST_WAIT: begin
            if (done)      state_d = ST_HALT;
            else if (step) state_d = ST_FETCH;
         end
`endif
         default: begin
            state_d = ST_HALT;
         end
      endcase

      // done is honoured only here, after the PC update has been decided.
      if (boundary) state_d = done ? ST_HALT : BOUNDARY_ST;
   end

   // Datapath strobes, decoded from the current state (ir_load also from mem_ready).
   always_comb begin
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      instr_fetch = 1'b0;
      ir_load     = 1'b0;
      alu_op      = '0;
      reg_write   = 1'b0;
      halted      = 1'b0;

      unique case (state_q)
         ST_FETCH: begin
            mem_read    = 1'b1;
            instr_fetch = 1'b1;
            ir_load     = mem_ready;
         end
         ST_EXEC: begin
            // Address arithmetic for LW/SW uses ADD; BEQ compares with SUB.
            if (is_beq)              alu_op = ALU_W'(3'b001);
            else if (is_lw || is_sw) alu_op = '0;
            else                     alu_op = ALU_W'(opc_low);
         end
         ST_MEM: begin
            mem_read  = is_lw;
            mem_write = is_sw;
         end
         ST_WB: begin
            reg_write = 1'b1;
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: begin
            mem_read = 1'b0;
         end
      endcase
   end

   assign pc    = pc_q;
   assign state = state_q;

endmodule
